// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner IDs, latency bounds.
package mem_arb_pkg;

  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Two-way requester picker. Fixed DBG-over-CPU priority by default; ARB_RR_EN
// adds a round-robin pointer that names the winner of the next tie.
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic   clk,
  input  logic   reset,
  input  logic   take,
`endif
  input  logic   cpu_req,
  input  logic   dbg_req,
  output owner_e gnt_own_c,
  output logic   gnt_valid_c
);

  assign gnt_valid_c = cpu_req | dbg_req;

`ifdef ARB_RR_EN
  owner_e ptr_q, ptr_d;

  // Lone requester wins; ties go to the pointer, which then names the loser.
  always_comb begin
    gnt_own_c = dbg_req ? OWN_DBG : OWN_CPU;
    if (cpu_req && dbg_req) begin
      gnt_own_c = ptr_q;
    end
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (gnt_own_c == OWN_DBG) ? OWN_CPU : OWN_DBG;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= OWN_DBG;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt_own_c = dbg_req ? OWN_DBG : OWN_CPU;
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the CPU datapath and a debug/loader port.
// Each access runs LAT memory cycles then a one-cycle ack; ARB_RR_EN selects round-robin.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;

  owner_e            gnt_own_c;
  logic              gnt_valid_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

`ifdef ARB_RR_EN
  logic take_c;
  assign take_c = (state_q == ST_IDLE) & gnt_valid_c;
`endif

  arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk         (clk),
    .reset       (reset),
    .take        (take_c),
`endif
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .gnt_own_c   (gnt_own_c),
    .gnt_valid_c (gnt_valid_c)
  );

  assign sel_we_c    = (gnt_own_c == OWN_DBG) ? dbg_we    : cpu_we;
  assign sel_addr_c  = (gnt_own_c == OWN_DBG) ? dbg_addr  : cpu_addr;
  assign sel_wdata_c = (gnt_own_c == OWN_DBG) ? dbg_wdata : cpu_wdata;

  // Next-state and registered-output logic; the memory strobes lead the state by one edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_d     = own_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          own_d    = gnt_own_c;
          we_d     = sel_we_c;
          addr_d   = {sel_addr_c[ADDR_W-1:1], 1'b0};
          wdata_d  = sel_wdata_c;
          cnt_d    = CNT_W'(LAT - 1);
          state_d  = ST_BUSY;
          mem_en_d = 1'b1;
          mem_we_d = sel_we_c;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d   = ST_RESP;
          cpu_ack_d = (own_q == OWN_CPU);
          dbg_ack_d = (own_q == OWN_DBG);
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      own_q     <= OWN_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      cpu_ack_q <= cpu_ack_d;
      dbg_ack_q <= dbg_ack_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Arbitrates the single-port data Memory between two requesters: the CPU datapath (load/store/push/pop) and a debug/loader port.
- Sequences each access over a fixed memory latency.
- Drives `cpu_stall` so the PC and SP hold their `change` while a CPU access is pending.
- Sits between the CPU top level and Memory; replaces the direct `res`/`DR_value`/`DataOut` wiring.

Parameters:
- `DATA_W`, 16, data width.
- `ADDR_W`, 16, byte address width.
- `LAT`, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request, level; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  `ADDR_W`  byte address.
- `cpu_wdata`  in  `DATA_W`  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  `DATA_W`  read data, valid with `cpu_ack`.
- `cpu_stall`  out  1  high while `cpu_req` is high and `cpu_ack` is low (combinational).
- `dbg_req`  in  1  debug access request, level.
- `dbg_we`  in  1  debug write enable.
- `dbg_addr`  in  `ADDR_W`  debug address.
- `dbg_wdata`  in  `DATA_W`  debug write data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  `DATA_W`  read data, valid with `dbg_ack`.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write, qualified by `mem_en`.
- `mem_addr`  out  `ADDR_W`  memory address; bit 0 forced to 0.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `mem_rdata`  in  `DATA_W`  memory read data; valid on the last `BUSY` cycle.
- `busy`  out  1  high when the state is not `IDLE`.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - State goes to `IDLE`; count = 0; priority pointer = DBG.
  - All acks, `mem_en`, `mem_we` and `busy` = 0.
  - `mem_addr`, `mem_wdata` and the read-data register = 0.
  - A reset in mid-transaction aborts it immediately. No ack is issued and the write may be partial.
- FSM states: `IDLE`, `BUSY`, `RESP`.
- `IDLE`:
  - If any request is high, pick an owner and latch its `we`, `addr` (with `[0]` cleared) and `wdata`.
  - Load count = `LAT` - 1 and go to `BUSY` on the next edge.
  - With no request, stay in `IDLE`.
- `BUSY`:
  - `mem_en` = 1; `mem_we` = latched `we`; address and data come from the latch and are stable every `BUSY` cycle.
  - Count decrements each cycle. When count = 0:
    - on a read, register `mem_rdata` into the read-data register;
    - go to `RESP`.
- `RESP`:
  - Pulse the owner's ack for 1 cycle with `mem_en` = 0, then return to `IDLE`.
  - `cpu_rdata` and `dbg_rdata` both drive the shared read-data register.
  - Writes leave the read-data register unchanged.
- Latency: request high in `IDLE` at cycle 0 gives ack at cycle `LAT`+1. Throughput is one transaction per `LAT`+2 cycles.
- Request protocol:
  - A requester must drop `req` in the cycle after its ack; `req` still high in `IDLE` is a new request.
  - `req`, `we`, `addr` and `wdata` changes after grant are ignored until the next `IDLE`.
- Simultaneous requests: fixed priority, DBG over CPU. The loser stays pending, and `cpu_stall` stays high while the CPU loses.
- A request arriving while the state is not `IDLE` waits; there is no queueing beyond the level request.
- `LAT` = 1: a single `BUSY` cycle.

Optional Feature:
- Macro: `ARB_RR_EN`.
- When defined: round-robin arbitration.
  - The pointer flips to the non-granted requester on each grant.
  - On a tie, the requester named by the pointer wins.
  - A lone requester always wins.
- When undefined: fixed DBG-over-CPU priority; no pointer register.

Decomposition:
- Shared package `mem_arb_pkg` holds:
  - state encodings `ST_IDLE`, `ST_BUSY`, `ST_RESP`;
  - owner IDs `OWN_CPU`, `OWN_DBG`;
  - `LAT_MAX` = 15 and the count width.
- Sub-module `arb_pick`: combinational two-way picker, plus the RR pointer flop under `ARB_RR_EN`. Outputs the grant owner and a grant-valid signal.
- The FSM, latch and read-data register stay in the top.

Test Plan:
- CPU read, `LAT`=2, `cpu_addr`=0x0011, memory returns 0xBEEF:
  - `mem_addr`=0x0010 and `mem_en` high in cycles 1–2;
  - `cpu_ack` at cycle 3 with `cpu_rdata`=0xBEEF;
  - `cpu_stall` high in cycles 0–2.
- DBG write 0x1234 to 0x0020, `LAT`=3:
  - `mem_en`=`mem_we`=1 with `mem_addr`=0x0020 and `mem_wdata`=0x1234 in cycles 1–3;
  - `dbg_ack` at cycle 4;
  - read-data register unchanged.
- `cpu_req` and `dbg_req` both high at cycle 0, each with `LAT`=2:
  - without `ARB_RR_EN`: `dbg_ack` at cycle 3, `cpu_ack` at cycle 7;
  - with `ARB_RR_EN` after a prior DBG grant: CPU is served first.
- Reset asserted in the 2nd `BUSY` cycle of a write:
  - `mem_en`, `mem_we` and `busy` fall immediately; no ack;
  - after release, state is `IDLE` and a new CPU read completes at `LAT`+1.
- Requester holds `cpu_req` high past the ack: a second transaction starts; both acks appear `LAT`+2 cycles apart.
- `LAT`=1 back-to-back CPU reads to 0x0000 and 0x0002 (second `req` raised after the first ack): acks at cycles 2 and 6.
